// File: rtl/ddr_traffic_gen.sv
// Write/read-back traffic generator for a MIG-style UI port: writes NUM_BURSTS
// patterned bursts, idles, reads them back and counts data mismatches.
module ddr_traffic_gen #(
  parameter int DATA_W      = 512,
  parameter int ADDR_W      = 28,
  parameter int NUM_BURSTS  = 256,
  parameter int ADDR_STRIDE = 8,
  parameter int WAIT_CYC    = 20,
  parameter int PATTERN     = 0
) (
  input  logic                ui_clk,
  input  logic                sys_rst,
  input  logic                init_calib_complete,
  input  logic                start,
  input  logic                loop_en,
  input  logic [31:0]         seed,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  input  logic                app_wdf_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid,
  output logic                app_sr_req,
  output logic                app_ref_req,
  output logic                app_zq_req,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_cnt,
  output logic [15:0]         first_err_idx,
  output logic [31:0]         pass_cnt
);
  localparam int CW = $clog2(NUM_BURSTS + 1);
  localparam int WW = $clog2(WAIT_CYC + 2);
  localparam logic [CW-1:0] LAST = CW'(NUM_BURSTS);

  typedef enum logic [2:0] {IDLE, WRITE, WAIT, READ, DRAIN, CHECK} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     c_q, c_d, d_q, d_d, r_q, r_d, c_nx, d_nx;
  logic [WW-1:0]     wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        cmd_q, cmd_d;
  logic              en_q, en_d, wren_q, wren_d, pass_q, pass_d;
  logic [31:0]       seed_q, seed_d, pass_cnt_q, pass_cnt_d;
  logic [15:0]       err_q, err_d, ferr_q, ferr_d;
  logic              cmd_acc, beat_acc, rd_hit, launch, enter_read;

  function automatic logic [DATA_W-1:0] pattern(input logic [31:0] v);
    logic [DATA_W-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_W / 32; i++)
      p[i*32 +: 32] = (PATTERN == 1 && (i % 2) == 1) ? ~v : v;
    return p;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    c_d        = c_q;
    d_d        = d_q;
    r_d        = r_q;
    wait_d     = wait_q;
    addr_d     = addr_q;
    cmd_d      = cmd_q;
    en_d       = en_q;
    wren_d     = wren_q;
    seed_d     = seed_q;
    err_d      = err_q;
    ferr_d     = ferr_q;
    pass_d     = pass_q;
    pass_cnt_d = pass_cnt_q;
    launch     = 1'b0;
    enter_read = 1'b0;

    cmd_acc  = en_q & app_rdy;
    beat_acc = wren_q & app_wdf_rdy;
    c_nx     = c_q + CW'(cmd_acc);
    d_nx     = d_q + CW'(beat_acc);
    if (cmd_acc) addr_d = addr_q + ADDR_W'(ADDR_STRIDE);

    rd_hit = (state_q == READ || state_q == DRAIN) && app_rd_data_valid && (r_q != LAST);
    if (rd_hit) begin
      r_d = r_q + CW'(1);
      if (app_rd_data != pattern(seed_q + 32'(r_q))) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (err_q == 16'd0)    ferr_d = 16'(r_q);
      end
    end

    case (state_q)
      IDLE: begin
        launch = start && init_calib_complete;
        if (launch) seed_d = seed;
      end
      WRITE: begin
        c_d    = c_nx;
        d_d    = d_nx;
        wren_d = (d_nx != LAST);
        // A new command is only offered while write data trails it by at most two.
        en_d   = (c_nx != LAST) && (32'(c_nx) <= 32'(d_nx) + 32'd2);
        if (c_q == LAST && d_q == LAST) begin
          if (WAIT_CYC == 0) begin
            enter_read = 1'b1;
          end else begin
            state_d = WAIT;
            wait_d  = '0;
          end
        end
      end
      WAIT: begin
        if (wait_q == WW'(WAIT_CYC - 1)) enter_read = 1'b1;
        else                             wait_d = wait_q + WW'(1);
      end
      READ: begin
        c_d  = c_nx;
        en_d = (c_nx != LAST);
        if (c_nx == LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (r_q == LAST) state_d = CHECK;
      end
      CHECK: begin
        pass_d     = (err_q == 16'd0);
        pass_cnt_d = pass_cnt_q + 32'd1;
        launch     = loop_en;
        if (!loop_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (enter_read) begin
      state_d = READ;
      c_d     = '0;
      addr_d  = '0;
      cmd_d   = 3'b001;
      en_d    = 1'b0;
    end

    if (launch) begin
      state_d = WRITE;
      c_d     = '0;
      d_d     = '0;
      r_d     = '0;
      addr_d  = '0;
      cmd_d   = 3'b000;
      en_d    = 1'b0;
      wren_d  = 1'b0;
      err_d   = '0;
      ferr_d  = '0;
    end

    // Losing calibration aborts the pass without reporting a result.
    if (state_q != IDLE && !init_calib_complete) begin
      state_d    = IDLE;
      en_d       = 1'b0;
      wren_d     = 1'b0;
      pass_d     = 1'b0;
      pass_cnt_d = pass_cnt_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      c_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      wait_q     <= '0;
      addr_q     <= '0;
      cmd_q      <= 3'b000;
      en_q       <= 1'b0;
      wren_q     <= 1'b0;
      seed_q     <= '0;
      err_q      <= '0;
      ferr_q     <= '0;
      pass_q     <= 1'b0;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      d_q        <= d_d;
      r_q        <= r_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      cmd_q      <= cmd_d;
      en_q       <= en_d;
      wren_q     <= wren_d;
      seed_q     <= seed_d;
      err_q      <= err_d;
      ferr_q     <= ferr_d;
      pass_q     <= pass_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  assign app_addr      = addr_q;
  assign app_cmd       = cmd_q;
  assign app_en        = en_q;
  assign app_wdf_wren  = wren_q;
  assign app_wdf_end   = wren_q;
  assign app_wdf_data  = wren_q ? pattern(seed_q + 32'(d_q)) : '0;
  assign app_wdf_mask  = '0;
  assign app_sr_req    = 1'b0;
  assign app_ref_req   = 1'b0;
  assign app_zq_req    = 1'b0;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == CHECK) && init_calib_complete;
  assign pass          = pass_q;
  assign err_cnt       = err_q;
  assign first_err_idx = ferr_q;
  assign pass_cnt      = pass_cnt_q;
endmodule
